// File: rtl/traffic_sink.sv
// Receive-side traffic endpoint: grants the generator, checks HEAD/BODY/TAIL format, address and body count, keeps stats.
// Outputs registered one cycle after the flit edge; no backpressure, a flit is consumed every cycle it is presented.

package router_pkg;
    typedef enum logic [1:0] {
        NONE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [7:0] xaddr;
        logic [7:0] yaddr;
    } head_t;

    typedef struct packed {
        logic [15:0] data;
    } body_t;

    typedef union packed {
        head_t head;
        body_t body;
    } payload_t;

    typedef struct packed {
        logic       valid;
        flit_type_t flit_type;
        payload_t   payload;
    } FLIT_t;

    localparam int FLIT_SIZE = $bits(FLIT_t);
endpackage

module traffic_sink
    import router_pkg::*;
#(
    parameter int         BODY_COUNT = 2,
    parameter logic [7:0] MY_X       = 8'd0,
    parameter logic [7:0] MY_Y       = 8'd1,
    parameter int         TIMEOUT    = 16,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_req,
    input  FLIT_t            i_flit,
    output logic             o_send,
    output logic             o_pkt_done,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic [CNT_W-1:0] o_pkt_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [15:0]      o_last_data,
    output logic             o_busy
);

    localparam int BC_W = $clog2(BODY_COUNT) + 1;
    localparam int TM_W = $clog2(TIMEOUT + 1);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(BODY_COUNT);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT - 1);

    localparam logic [2:0] E_TYPE    = 3'd1;
    localparam logic [2:0] E_ADDR    = 3'd2;
    localparam logic [2:0] E_COUNT   = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;
    localparam logic [2:0] E_NONE    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_HEAD,
        ST_BODY,
        ST_WAIT_TAIL,
        ST_DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TM_W-1:0] timer;
    logic [BC_W-1:0] body_cnt;
    logic [BC_W-1:0] body_cnt_inc;

    logic       present;
    flit_type_t ftype;
    logic       addr_ok;
    logic       timed;
    logic       timer_hit;

    logic       err_det;
    logic [2:0] err_code_det;
    logic       done_det;
    logic       body_acc;

    assign present      = i_flit.valid;
    assign ftype        = i_flit.flit_type;
    assign addr_ok      = (i_flit.payload.head.xaddr == MY_X) && (i_flit.payload.head.yaddr == MY_Y);
    assign timed        = (state == ST_WAIT_HEAD) || (state == ST_BODY) ||
                          (state == ST_WAIT_TAIL) || (state == ST_DROP);
    assign timer_hit    = timed && !present && (timer == TM_LAST);
    assign body_cnt_inc = body_cnt + BC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_enable && i_req) state_nxt = ST_GRANT;
            end
            ST_GRANT: state_nxt = ST_WAIT_HEAD;
            ST_WAIT_HEAD: begin
                if (present) begin
                    if (ftype == HEAD && addr_ok)
                        state_nxt = (BODY_COUNT == 0) ? ST_WAIT_TAIL : ST_BODY;
                    else
                        state_nxt = ST_DROP;
                end else if (timer_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (present) begin
                    case (ftype)
                        BODY:    if (body_cnt_inc == BC_MAX) state_nxt = ST_WAIT_TAIL;
                        TAIL:    state_nxt = ST_IDLE;
                        default: state_nxt = ST_DROP;
                    endcase
                end else if (timer_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_TAIL: begin
                if (present)
                    state_nxt = (ftype == TAIL) ? ST_IDLE : ST_DROP;
                else if (timer_hit)
                    state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if ((present && ftype == TAIL) || timer_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Detection happens here; the results are registered below so pulses trail the flit by one cycle.
    always_comb begin
        err_det      = 1'b0;
        err_code_det = 3'd0;
        done_det     = 1'b0;
        body_acc     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (present) begin
                    err_det      = 1'b1;
                    err_code_det = E_TYPE;
                end
            end
            ST_WAIT_HEAD: begin
                if (present) begin
                    case (ftype)
                        HEAD: begin
                            err_det      = !addr_ok;
                            err_code_det = E_ADDR;
                        end
                        NONE: begin
                            err_det      = 1'b1;
                            err_code_det = E_NONE;
                        end
                        default: begin
                            err_det      = 1'b1;
                            err_code_det = E_TYPE;
                        end
                    endcase
                end else if (timer_hit) begin
                    err_det      = 1'b1;
                    err_code_det = E_TIMEOUT;
                end
            end
            ST_BODY, ST_WAIT_TAIL: begin
                if (present) begin
                    case (ftype)
                        BODY: begin
                            if (state == ST_BODY) begin
                                body_acc = 1'b1;
                            end else begin
                                err_det      = 1'b1;
                                err_code_det = E_COUNT;
                            end
                        end
                        TAIL: begin
                            if (state == ST_WAIT_TAIL) begin
                                done_det = 1'b1;
                            end else begin
                                err_det      = 1'b1;
                                err_code_det = E_COUNT;
                            end
                        end
                        HEAD: begin
                            err_det      = 1'b1;
                            err_code_det = E_TYPE;
                        end
                        default: begin
                            err_det      = 1'b1;
                            err_code_det = E_NONE;
                        end
                    endcase
                end else if (timer_hit) begin
                    err_det      = 1'b1;
                    err_code_det = E_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_send      <= 1'b0;
            o_pkt_done  <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 3'd0;
            o_pkt_count <= '0;
            o_err_count <= '0;
            o_last_data <= 16'd0;
            o_busy      <= 1'b0;
            timer       <= '0;
            body_cnt    <= '0;
        end else begin
            o_send     <= (state_nxt == ST_GRANT);
            o_busy     <= (state_nxt != ST_IDLE);
            o_pkt_done <= done_det;
            o_err      <= err_det;

            if (!timed || present || state_nxt == ST_IDLE)
                timer <= '0;
            else
                timer <= timer + TM_W'(1);

            if (state == ST_GRANT)
                body_cnt <= '0;
            else if (body_acc)
                body_cnt <= body_cnt_inc;

            if (body_acc) o_last_data <= i_flit.payload.body.data;

            if (err_det) begin
                o_err_code <= err_code_det;
                if (o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
            end

            if (done_det && o_pkt_count != '1) o_pkt_count <= o_pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: vector table for single-cycle behaviour, hand sequences for timing corners.
module tb_traffic_sink;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_req = 1'b0;
    FLIT_t       i_flit = '0;

    logic        o_send, o_pkt_done, o_err, o_busy;
    logic [2:0]  o_err_code;
    logic [15:0] o_pkt_count, o_err_count, o_last_data;

    logic        s_send, s_pkt_done, s_err, s_busy;
    logic [2:0]  s_err_code;
    logic [1:0]  s_pkt_count, s_err_count;
    logic [15:0] s_last_data;

    traffic_sink dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_req(i_req), .i_flit(i_flit),
        .o_send(o_send), .o_pkt_done(o_pkt_done), .o_err(o_err), .o_err_code(o_err_code),
        .o_pkt_count(o_pkt_count), .o_err_count(o_err_count), .o_last_data(o_last_data),
        .o_busy(o_busy)
    );

    traffic_sink #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_req(i_req), .i_flit(i_flit),
        .o_send(s_send), .o_pkt_done(s_pkt_done), .o_err(s_err), .o_err_code(s_err_code),
        .o_pkt_count(s_pkt_count), .o_err_count(s_err_count), .o_last_data(s_last_data),
        .o_busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        en;
        FLIT_t       flit;
        logic        send;
        logic        done;
        logic        err;
        logic [2:0]  code;
        logic        busy;
        logic [15:0] pkt;
        logic [15:0] errc;
        logic [15:0] last;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass = 0;
    logic err_seen;

    function automatic FLIT_t mk(input flit_type_t t, input logic [15:0] p);
        FLIT_t f;
        f.valid        = 1'b1;
        f.flit_type    = t;
        f.payload.body = p;
        return f;
    endfunction

    function automatic FLIT_t hd(input logic [7:0] x, input logic [7:0] y);
        return mk(HEAD, {x, y});
    endfunction

    function automatic FLIT_t bd(input logic [15:0] d);
        return mk(BODY, d);
    endfunction

    function automatic FLIT_t tl();
        return mk(TAIL, 16'd0);
    endfunction

    function automatic FLIT_t zz();
        return '0;
    endfunction

    function automatic vec_t v(input logic req, input logic en, input FLIT_t f,
                               input logic send, input logic done, input logic err,
                               input logic [2:0] code, input logic busy,
                               input int pkt, input int errc, input logic [15:0] last);
        vec_t r;
        r.req = req; r.en = en; r.flit = f;
        r.send = send; r.done = done; r.err = err; r.code = code; r.busy = busy;
        r.pkt = 16'(pkt); r.errc = 16'(errc); r.last = last;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic track_step();
        step();
        if (o_err) err_seen = 1'b1;
    endtask

    task automatic send_good(input logic [15:0] d0, input logic [15:0] d1);
        i_req = 1'b1; step();
        i_req = 1'b0; step();
        step();
        i_flit = hd(8'd0, 8'd1); step();
        i_flit = bd(d0); step();
        i_flit = bd(d1); step();
        i_flit = tl(); step();
        i_flit = zz();
    endtask

    initial begin
        // good packet
        tbl.push_back(v(1,1,zz(),      1,0,0,0,1, 0,0,16'h0000));
        tbl.push_back(v(0,1,zz(),      0,0,0,0,1, 0,0,16'h0000));
        tbl.push_back(v(0,1,zz(),      0,0,0,0,1, 0,0,16'h0000));
        tbl.push_back(v(0,1,hd(0,1),   0,0,0,0,1, 0,0,16'h0000));
        tbl.push_back(v(0,1,bd(16'h5), 0,0,0,0,1, 0,0,16'h0005));
        tbl.push_back(v(0,1,bd(16'h6), 0,0,0,0,1, 0,0,16'h0006));
        tbl.push_back(v(0,1,tl(),      0,1,0,0,0, 1,0,16'h0006));
        tbl.push_back(v(0,1,zz(),      0,0,0,0,0, 1,0,16'h0006));
        // address mismatch
        tbl.push_back(v(1,1,zz(),      1,0,0,0,1, 1,0,16'h0006));
        tbl.push_back(v(0,1,zz(),      0,0,0,0,1, 1,0,16'h0006));
        tbl.push_back(v(0,1,hd(2,3),   0,0,1,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,bd(16'h7), 0,0,0,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,bd(16'h8), 0,0,0,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,tl(),      0,0,0,2,0, 1,1,16'h0006));
        // short packet
        tbl.push_back(v(1,1,zz(),      1,0,0,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,zz(),      0,0,0,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,hd(0,1),   0,0,0,2,1, 1,1,16'h0006));
        tbl.push_back(v(0,1,bd(16'h9), 0,0,0,2,1, 1,1,16'h0009));
        tbl.push_back(v(0,1,tl(),      0,0,1,3,0, 1,2,16'h0009));
        // long packet
        tbl.push_back(v(1,1,zz(),      1,0,0,3,1, 1,2,16'h0009));
        tbl.push_back(v(0,1,zz(),      0,0,0,3,1, 1,2,16'h0009));
        tbl.push_back(v(0,1,hd(0,1),   0,0,0,3,1, 1,2,16'h0009));
        tbl.push_back(v(0,1,bd(16'hA), 0,0,0,3,1, 1,2,16'h000A));
        tbl.push_back(v(0,1,bd(16'hB), 0,0,0,3,1, 1,2,16'h000B));
        tbl.push_back(v(0,1,bd(16'hC), 0,0,1,3,1, 1,3,16'h000B));
        tbl.push_back(v(0,1,tl(),      0,0,0,3,0, 1,3,16'h000B));
        // stray body in idle, then enable gating
        tbl.push_back(v(0,1,bd(16'hD), 0,0,1,1,0, 1,4,16'h000B));
        tbl.push_back(v(1,0,zz(),      0,0,0,1,0, 1,4,16'h000B));
        tbl.push_back(v(1,1,zz(),      1,0,0,1,1, 1,4,16'h000B));
        tbl.push_back(v(0,0,zz(),      0,0,0,1,1, 1,4,16'h000B));
        tbl.push_back(v(0,0,hd(0,1),   0,0,0,1,1, 1,4,16'h000B));
        tbl.push_back(v(0,0,bd(16'h11),0,0,0,1,1, 1,4,16'h0011));
        tbl.push_back(v(0,0,bd(16'h12),0,0,0,1,1, 1,4,16'h0012));
        tbl.push_back(v(0,0,tl(),      0,1,0,1,0, 2,4,16'h0012));
        // valid flit with NONE type while waiting for head
        tbl.push_back(v(1,1,zz(),      1,0,0,1,1, 2,4,16'h0012));
        tbl.push_back(v(0,1,zz(),      0,0,0,1,1, 2,4,16'h0012));
        tbl.push_back(v(0,1,mk(NONE,16'h0), 0,0,1,5,1, 2,5,16'h0012));
        tbl.push_back(v(0,1,tl(),      0,0,0,5,0, 2,5,16'h0012));

        reset = 1'b1;
        step(); step();
        chk("rst_send", 0, o_send, 0);
        chk("rst_done", 0, o_pkt_done, 0);
        chk("rst_err", 0, o_err, 0);
        chk("rst_code", 0, o_err_code, 0);
        chk("rst_pkt", 0, o_pkt_count, 0);
        chk("rst_errc", 0, o_err_count, 0);
        chk("rst_last", 0, o_last_data, 0);
        chk("rst_busy", 0, o_busy, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            i_req = tbl[i].req; i_enable = tbl[i].en; i_flit = tbl[i].flit;
            step();
            chk("send", i, o_send, tbl[i].send);
            chk("done", i, o_pkt_done, tbl[i].done);
            chk("err", i, o_err, tbl[i].err);
            chk("code", i, o_err_code, tbl[i].code);
            chk("busy", i, o_busy, tbl[i].busy);
            chk("pkt", i, o_pkt_count, tbl[i].pkt);
            chk("errc", i, o_err_count, tbl[i].errc);
            chk("last", i, o_last_data, tbl[i].last);
        end
        i_req = 1'b0; i_enable = 1'b1; i_flit = zz();

        // timeout waiting for head: error on the 16th empty cycle
        i_req = 1'b1; step();
        i_req = 1'b0; step();
        err_seen = 1'b0;
        repeat (15) track_step();
        chk("to_early_err", 0, err_seen, 0);
        chk("to_early_busy", 0, o_busy, 1);
        step();
        chk("to_err", 0, o_err, 1);
        chk("to_code", 0, o_err_code, 4);
        chk("to_busy", 0, o_busy, 0);
        chk("to_errc", 0, o_err_count, 6);

        // timeout inside DROP leaves silently
        i_req = 1'b1; step();
        i_req = 1'b0; step();
        i_flit = hd(8'd5, 8'd5); step();
        i_flit = zz();
        chk("drop_err", 0, o_err, 1);
        chk("drop_code", 0, o_err_code, 2);
        err_seen = 1'b0;
        repeat (15) track_step();
        chk("drop_busy_hold", 0, o_busy, 1);
        track_step();
        chk("drop_busy_exit", 0, o_busy, 0);
        chk("drop_silent", 0, err_seen, 0);
        chk("drop_errc", 0, o_err_count, 7);

        // 15-cycle gaps never trip the timer
        i_req = 1'b1; step();
        i_req = 1'b0; step();
        err_seen = 1'b0;
        repeat (15) track_step();
        i_flit = hd(8'd0, 8'd1); track_step(); i_flit = zz();
        repeat (15) track_step();
        i_flit = bd(16'h21); track_step(); i_flit = zz();
        repeat (15) track_step();
        i_flit = bd(16'h22); track_step(); i_flit = zz();
        repeat (15) track_step();
        i_flit = tl(); track_step(); i_flit = zz();
        chk("gap_done", 0, o_pkt_done, 1);
        chk("gap_no_err", 0, err_seen, 0);
        chk("gap_pkt", 0, o_pkt_count, 3);
        chk("gap_last", 0, o_last_data, 16'h0022);

        // reset mid-packet
        i_req = 1'b1; step();
        i_req = 1'b0; step();
        i_flit = hd(8'd0, 8'd1); step();
        i_flit = bd(16'h31); step();
        i_flit = zz();
        reset = 1'b1; step();
        reset = 1'b0;
        chk("mrst_send", 0, o_send, 0);
        chk("mrst_done", 0, o_pkt_done, 0);
        chk("mrst_err", 0, o_err, 0);
        chk("mrst_code", 0, o_err_code, 0);
        chk("mrst_pkt", 0, o_pkt_count, 0);
        chk("mrst_errc", 0, o_err_count, 0);
        chk("mrst_last", 0, o_last_data, 0);
        chk("mrst_busy", 0, o_busy, 0);
        chk("mrst_sat_state", 0, {s_send, s_pkt_done, s_err, s_err_code, s_busy}, 0);
        chk("mrst_sat_cnt", 0, {s_pkt_count, s_err_count, s_last_data}, 0);

        send_good(16'h41, 16'h42);
        chk("fresh_pkt", 0, o_pkt_count, 1);
        chk("fresh_errc", 0, o_err_count, 0);
        chk("fresh_last", 0, o_last_data, 16'h0042);

        // saturation with a 2-bit counter
        repeat (4) send_good(16'h51, 16'h52);
        chk("sat_pkt_wide", 0, o_pkt_count, 5);
        chk("sat_pkt", 0, s_pkt_count, 3);
        chk("sat_errc", 0, s_err_count, 0);

        i_flit = bd(16'h55); step();
        i_flit = zz();
        chk("stray_err", 0, o_err, 1);
        chk("stray_code", 0, o_err_code, 1);
        chk("stray_send", 0, o_send, 0);
        chk("stray_busy", 0, o_busy, 0);
        chk("stray_sat_errc", 0, s_err_count, 1);
        step();
        chk("stray_no_grant", 0, o_send, 0);
        chk("stray_pulse_end", 0, o_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
